// File: rtl/tagged_mem_mc_pkg.sv
// Shared types and helpers for the multi-channel valid-tracked memory.
package tagged_mem_mc_pkg;

    // state    | meaning
    // ST_IDLE  | no drain in progress
    // ST_SCAN  | examining valid[ptr], one address per cycle
    // ST_FETCH | waiting for memory read data
    // ST_OUT   | presenting the word on the drain stream
    // ST_DONE  | one-cycle drain_done pulse
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FETCH = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } drain_st_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    // LSB of lane 'lane' in a flattened bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/tagged_mem_mc_if.sv
// Bus bundle for tagged_mem_mc: write channels, read port, clear and drain stream.
interface tagged_mem_mc_if #(
    parameter int A   = 9,
    parameter int S   = 24,
    parameter int NCH = 2
);
    logic [NCH-1:0]   wr_valid;
    logic [NCH-1:0]   wr_ready;
    logic [NCH*A-1:0] wr_addr;
    logic [NCH*S-1:0] wr_data;
    logic             rd_en;
    logic [A-1:0]     rd_addr;
    logic             rd_vld;
    logic [S-1:0]     rd_data;
    logic             rd_hit;
    logic             clear_req;
    logic             drain_req;
    logic             dr_valid;
    logic             dr_ready;
    logic [A-1:0]     dr_addr;
    logic [S-1:0]     dr_data;
    logic             busy;
    logic             drain_done;
    logic [A:0]       count;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_en, rd_addr, clear_req, drain_req, dr_ready,
        output wr_ready, rd_vld, rd_data, rd_hit, dr_valid, dr_addr, dr_data, busy,
               drain_done, count
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_en, rd_addr, clear_req, drain_req, dr_ready,
        input  wr_ready, rd_vld, rd_data, rd_hit, dr_valid, dr_addr, dr_data, busy,
               drain_done, count
    );
endinterface

// File: rtl/tagged_mem_mc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the channel after the last grant.
module rr_arbiter #(
    parameter int NCH = 2
) (
    input  logic           clock_out,
    input  logic           reset,
    input  logic [NCH-1:0] req_i,
    output logic [NCH-1:0] gnt_o
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == NCH - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clock_out) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/tagged_mem_mc.sv
// Multi-channel valid-tracked memory with read port, bulk clear and drain stream.
module tagged_mem_mc
    import tagged_mem_mc_pkg::*;
#(
    parameter int A      = 9,
    parameter int S      = 24,
    parameter int NCH    = 2,
    parameter int RD_LAT = 1
) (
    input  logic           clock_out,
    input  logic           reset,
    tagged_mem_mc_if.slave bus
);
    // Out-of-range latencies fall back to single-cycle reads.
    localparam int          LAT       = rd_lat_legal(RD_LAT) ? RD_LAT : 1;
    localparam int          DEPTH     = 2 ** A;
    localparam logic [A-1:0] LAST_ADDR = '1;

    logic [S-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [A:0]       count_q;

    drain_st_e    state_q;
    logic [A-1:0] ptr_q;
    logic         busy_q;
    logic         done_q;
    logic         dr_valid_q;
    logic [A-1:0] dr_addr_q;
    logic [S-1:0] dr_data_q;
    logic [S-1:0] fdata_q;
    logic         fcnt_q;

    logic [NCH-1:0] req;
    logic [NCH-1:0] gnt;
    logic           wr_open;
    logic           w_fire;
    logic [A-1:0]   w_addr;
    logic [S-1:0]   w_data;
    logic           drain_ack;
    logic           drain_end;
    logic           rd_acc;

    assign wr_open      = ~(reset | bus.clear_req | busy_q);
    assign req          = bus.wr_valid & {NCH{wr_open}};
    assign bus.wr_ready = gnt;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clock_out (clock_out),
        .reset     (reset),
        .req_i     (req),
        .gnt_o     (gnt)
    );

    always_comb begin
        w_fire = |gnt;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                w_addr = bus.wr_addr[lane_lsb(i, A) +: A];
                w_data = bus.wr_data[lane_lsb(i, S) +: S];
            end
        end
    end

    always_ff @(posedge clock_out) begin
        if (w_fire) mem_q[w_addr] <= w_data;
    end

    // Writes are blocked while busy, so a write and a drain acceptance never coincide.
    assign drain_ack = (state_q == ST_OUT) & dr_valid_q & bus.dr_ready & ~bus.clear_req;

    always_ff @(posedge clock_out) begin
        if (reset || bus.clear_req) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (w_fire) begin
            valid_q[w_addr] <= 1'b1;
            if (!valid_q[w_addr]) count_q <= count_q + (A+1)'(1);
        end else if (drain_ack) begin
            valid_q[ptr_q] <= 1'b0;
            count_q        <= count_q - (A+1)'(1);
        end
    end

    always_comb begin
        drain_end = 1'b0;
        if (state_q inside {ST_SCAN, ST_FETCH, ST_OUT}) begin
            drain_end = bus.clear_req
                     || (state_q == ST_SCAN && !valid_q[ptr_q] && ptr_q == LAST_ADDR)
                     || (state_q == ST_OUT && bus.dr_ready && ptr_q == LAST_ADDR);
        end
    end

    always_ff @(posedge clock_out) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dr_valid_q <= 1'b0;
            dr_addr_q  <= '0;
            dr_data_q  <= '0;
            fdata_q    <= '0;
            fcnt_q     <= 1'b0;
        end else if (drain_end) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            dr_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.drain_req && !bus.clear_req) begin
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (valid_q[ptr_q]) begin
                        fdata_q <= mem_q[ptr_q];
                        fcnt_q  <= (LAT == 2);
                        state_q <= ST_FETCH;
                    end else begin
                        ptr_q <= ptr_q + A'(1);
                    end
                end
                ST_FETCH: begin
                    if (fcnt_q) begin
                        fcnt_q <= 1'b0;
                    end else begin
                        dr_valid_q <= 1'b1;
                        dr_addr_q  <= ptr_q;
                        dr_data_q  <= fdata_q;
                        state_q    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.dr_ready) begin
                        dr_valid_q <= 1'b0;
                        ptr_q      <= ptr_q + A'(1);
                        state_q    <= ST_SCAN;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_acc = bus.rd_en & ~busy_q;

    logic         rd_vld1_q;
    logic [S-1:0] rd_data1_q;
    logic         rd_hit1_q;

    // Read-first: the registered sample sees memory and valid bits before this edge's write.
    always_ff @(posedge clock_out) begin
        if (reset) begin
            rd_vld1_q  <= 1'b0;
            rd_data1_q <= '0;
            rd_hit1_q  <= 1'b0;
        end else begin
            rd_vld1_q <= rd_acc;
            if (rd_acc) begin
                rd_hit1_q  <= valid_q[bus.rd_addr];
                rd_data1_q <= valid_q[bus.rd_addr] ? mem_q[bus.rd_addr] : '0;
            end
        end
    end

    if (LAT == 2) begin : g_lat2
        logic         rd_vld2_q;
        logic [S-1:0] rd_data2_q;
        logic         rd_hit2_q;

        always_ff @(posedge clock_out) begin
            if (reset) begin
                rd_vld2_q  <= 1'b0;
                rd_data2_q <= '0;
                rd_hit2_q  <= 1'b0;
            end else begin
                rd_vld2_q <= rd_vld1_q;
                if (rd_vld1_q) begin
                    rd_data2_q <= rd_data1_q;
                    rd_hit2_q  <= rd_hit1_q;
                end
            end
        end

        assign bus.rd_vld  = rd_vld2_q;
        assign bus.rd_data = rd_data2_q;
        assign bus.rd_hit  = rd_hit2_q;
    end else begin : g_lat1
        assign bus.rd_vld  = rd_vld1_q;
        assign bus.rd_data = rd_data1_q;
        assign bus.rd_hit  = rd_hit1_q;
    end

    assign bus.dr_valid   = dr_valid_q;
    assign bus.dr_addr    = dr_addr_q;
    assign bus.dr_data    = dr_data_q;
    assign bus.busy       = busy_q;
    assign bus.drain_done = done_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_tagged_mem_mc.sv
// Directed-vector bench for tagged_mem_mc with hand-computed expectations.
module tb_tagged_mem_mc;
    localparam int A      = 9;
    localparam int S      = 24;
    localparam int NCH    = 2;
    localparam int RD_LAT = 1;

    logic clock_out = 1'b0;
    logic reset;

    always #5 clock_out = ~clock_out;

    tagged_mem_mc_if #(.A(A), .S(S), .NCH(NCH)) bus ();

    tagged_mem_mc #(.A(A), .S(S), .NCH(NCH), .RD_LAT(RD_LAT)) dut (
        .clock_out (clock_out),
        .reset     (reset),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_out);
        #1;
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp_d,
                          input logic exp_h);
        bus.rd_en   = 1'b1;
        bus.rd_addr = A'(addr);
        step();
        bus.rd_en = 1'b0;
        repeat (RD_LAT - 1) step();
        chk({tag, "_vld"}, 32'(bus.rd_vld), 32'd1);
        chk({tag, "_data"}, 32'(bus.rd_data), exp_d);
        chk({tag, "_hit"}, 32'(bus.rd_hit), 32'(exp_h));
    endtask

    task automatic write_one(input string tag, input int ch, input int addr,
                             input logic [31:0] data);
        logic granted;
        granted = 1'b0;
        bus.wr_addr[ch*A +: A] = A'(addr);
        bus.wr_data[ch*S +: S] = S'(data);
        bus.wr_valid[ch]       = 1'b1;
        for (int k = 0; k < 8 && !granted; k++) begin
            #1;
            if (bus.wr_ready[ch]) granted = 1'b1;
            step();
        end
        bus.wr_valid[ch] = 1'b0;
        chk(tag, 32'(granted), 32'd1);
    endtask

    logic [A-1:0] q_addr [$];
    logic [S-1:0] q_data [$];
    logic [A-1:0] exp_a [3];
    logic [S-1:0] exp_d [3];
    logic         seen;
    int           n;

    initial begin
        reset         = 1'b1;
        bus.wr_valid  = 2'b01;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.clear_req = 1'b0;
        bus.drain_req = 1'b0;
        bus.dr_ready  = 1'b0;

        // 1: reset state and unwritten read
        step();
        chk("wr_ready_in_reset", 32'(bus.wr_ready), 32'd0);
        step();
        bus.wr_valid = '0;
        reset        = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rd_vld", 32'(bus.rd_vld), 32'd0);
        chk("rst_dr_valid", 32'(bus.dr_valid), 32'd0);
        chk("rst_drain_done", 32'(bus.drain_done), 32'd0);
        rd_chk("rd_unwritten", 5, 32'h0, 1'b0);
        step();
        chk("rd_vld_strobe", 32'(bus.rd_vld), 32'd0);

        // 2: simultaneous requests, round-robin
        bus.wr_addr[0*A +: A] = 9'd3;
        bus.wr_data[0*S +: S] = 24'hAAAAAA;
        bus.wr_addr[1*A +: A] = 9'd4;
        bus.wr_data[1*S +: S] = 24'h555555;
        bus.wr_valid = 2'b11;
        #1;
        chk("rr_first", 32'(bus.wr_ready), 32'h1);
        step();
        #1;
        chk("rr_second", 32'(bus.wr_ready), 32'h2);
        step();
        bus.wr_valid = '0;
        chk("count_two", 32'(bus.count), 32'd2);
        rd_chk("rd_a3", 3, 32'hAAAAAA, 1'b1);
        rd_chk("rd_a4", 4, 32'h555555, 1'b1);

        // 3: rewrite with same-cycle read (read-first)
        bus.wr_addr[0*A +: A] = 9'd3;
        bus.wr_data[0*S +: S] = 24'h123456;
        bus.wr_valid = 2'b01;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 9'd3;
        #1;
        chk("rewrite_grant", 32'(bus.wr_ready), 32'h1);
        step();
        bus.wr_valid = '0;
        bus.rd_en    = 1'b0;
        chk("rf_vld", 32'(bus.rd_vld), 32'd1);
        chk("rf_data", 32'(bus.rd_data), 32'hAAAAAA);
        chk("rf_hit", 32'(bus.rd_hit), 32'd1);
        chk("rewrite_count", 32'(bus.count), 32'd2);
        rd_chk("rd_a3_new", 3, 32'h123456, 1'b1);

        // 4: clear, then drain 0/7/511 with backpressure
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        chk("clear_count", 32'(bus.count), 32'd0);
        rd_chk("rd_a3_cleared", 3, 32'h0, 1'b0);
        write_one("wr_a0", 1, 0, 32'h0A0A0A);
        write_one("wr_a7", 0, 7, 32'h070707);
        write_one("wr_a511", 1, 511, 32'h1FF1FF);
        chk("count_three", 32'(bus.count), 32'd3);
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        chk("drain_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 10 && !bus.dr_valid; k++) step();
        chk("drain_out_reached", 32'(bus.dr_valid), 32'd1);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 9'd7;
        for (int h = 0; h < 3; h++) begin
            chk("hold_valid", 32'(bus.dr_valid), 32'd1);
            chk("hold_addr", 32'(bus.dr_addr), 32'd0);
            chk("hold_data", 32'(bus.dr_data), 32'h0A0A0A);
            chk("rd_blocked_busy", 32'(bus.rd_vld), 32'd0);
            step();
        end
        bus.rd_en    = 1'b0;
        bus.dr_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            if (bus.dr_valid) begin
                q_addr.push_back(bus.dr_addr);
                q_data.push_back(bus.dr_data);
            end
            if (bus.drain_done) begin
                seen = 1'b1;
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end else begin
                step();
            end
        end
        chk("drain_done_seen", 32'(seen), 32'd1);
        chk("drain_words", 32'(q_addr.size()), 32'd3);
        exp_a[0] = 9'd0;   exp_d[0] = 24'h0A0A0A;
        exp_a[1] = 9'd7;   exp_d[1] = 24'h070707;
        exp_a[2] = 9'd511; exp_d[2] = 24'h1FF1FF;
        for (int i = 0; i < 3; i++) begin
            if (i < q_addr.size()) begin
                chk("drain_addr", 32'(q_addr[i]), 32'(exp_a[i]));
                chk("drain_data", 32'(q_data[i]), 32'(exp_d[i]));
            end else begin
                chk("drain_missing", 32'd0, 32'd1);
            end
        end
        chk("drain_count", 32'(bus.count), 32'd0);
        step();
        chk("drain_done_pulse", 32'(bus.drain_done), 32'd0);
        bus.dr_ready = 1'b0;

        // empty-memory drain: drain_done 2^A edges after the request edge
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        n = 0;
        for (int k = 0; k < 1000 && !bus.drain_done; k++) begin
            step();
            n++;
        end
        chk("empty_drain_edges", 32'(n), 32'd512);
        step();

        // 5: clear beats a same-cycle write
        write_one("wr_a20", 0, 20, 32'h141414);
        chk("count_one", 32'(bus.count), 32'd1);
        bus.wr_addr[0*A +: A] = 9'd9;
        bus.wr_data[0*S +: S] = 24'h090909;
        bus.wr_valid  = 2'b01;
        bus.clear_req = 1'b1;
        #1;
        chk("wr_ready_clear", 32'(bus.wr_ready), 32'd0);
        step();
        bus.wr_valid  = '0;
        bus.clear_req = 1'b0;
        chk("clear_wr_count", 32'(bus.count), 32'd0);
        rd_chk("rd_a9", 9, 32'h0, 1'b0);
        rd_chk("rd_a20", 20, 32'h0, 1'b0);

        // 6: reset during OUT
        write_one("wr_a1", 0, 1, 32'h010101);
        write_one("wr_a2", 1, 2, 32'h020202);
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        for (int k = 0; k < 10 && !bus.dr_valid; k++) step();
        chk("rst_out_reached", 32'(bus.dr_valid), 32'd1);
        chk("rst_out_addr", 32'(bus.dr_addr), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_dr_valid", 32'(bus.dr_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        seen = bus.drain_done;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.drain_done) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tagged_mem_mc.md
Name: tagged_mem_mc

Overview:
Multi-channel successor to the dual-port valid-tracked memory. Holds 2^A words of S bits, each with a per-address valid bit, in the clock_out domain. NCH write channels share the memory through a round-robin arbiter with valid/ready handshakes. Adds a configurable-latency read port, an occupancy counter, a one-cycle bulk clear, and a drain FSM that streams out and invalidates every valid entry, used to flush square/tile buffers between frames.

Parameters:
A, 9, address width; depth 2^A
S, 24, data width
NCH, 2, number of write channels (1..8)
RD_LAT, 1, read latency in cycles (1 or 2)

Ports:
clock_out  in  1  sole clock
reset  in  1  synchronous, active-high
wr_valid  in  NCH  per-channel write request
wr_ready  out  NCH  per-channel grant; combinational
wr_addr  in  NCH*A  channel i at bits [i*A +: A]
wr_data  in  NCH*S  channel i at bits [i*S +: S]
rd_en  in  1  read request
rd_addr  in  A  read address
rd_vld  out  1  read result strobe
rd_data  out  S  read data; 0 if the address is unwritten
rd_hit  out  1  address held valid data
clear_req  in  1  invalidate all entries
drain_req  in  1  start drain
dr_valid  out  1  drain stream valid
dr_ready  in  1  drain stream ready
dr_addr  out  A  address of drained word
dr_data  out  S  drained word
busy  out  1  drain in progress
drain_done  out  1  one-cycle pulse at end of drain
count  out  A+1  number of valid entries

Behaviour:
- Reset (reset=1 at a clock_out edge):
  - All valid bits and count go to 0. Round-robin pointer goes to 0. FSM goes to IDLE.
  - All outputs go to 0. Memory contents are not reset.
- Write arbitration:
  - At most one write per cycle. Only one bit of wr_ready is high, and only if that channel has wr_valid.
  - Round-robin starts the search at the channel after the last granted one.
  - A write happens when wr_valid[i] and wr_ready[i] are both high: mem[addr] <= data and valid[addr] <= 1.
  - count increments only if the address was previously invalid.
- wr_ready is forced to 0 when any of these hold: reset, clear_req, busy.
- Read:
  - If rd_en is accepted in cycle t, rd_vld/rd_data/rd_hit are presented at t+RD_LAT. rd_vld is a one-cycle strobe.
  - Reads are read-first: a same-cycle write to the same address is not visible, and rd_hit reflects the old valid bit.
  - rd_en is ignored while busy (no rd_vld).
  - rd_data and rd_hit hold their last values between strobes.
- Clear:
  - When clear_req=1, all valid bits and count are 0 on the next cycle. No write is granted in that cycle.
  - Clear has priority over writes and over drain_req.
- Drain FSM, states IDLE, SCAN, FETCH, OUT, DONE:
  - IDLE: drain_req=1 (and clear_req=0) sets ptr=0, busy=1, and moves to SCAN.
  - SCAN: if valid[ptr]=1, issue an internal read and go to FETCH. If not, advance ptr. If ptr=2^A-1 and it is invalid, go to DONE. One address is examined per cycle.
  - FETCH: wait for the memory data (RD_LAT cycles), then go to OUT.
  - OUT: dr_valid=1 with dr_addr/dr_data stable until dr_ready=1. On acceptance, valid[ptr] <= 0 and count decrements. If ptr=2^A-1, go to DONE; otherwise ptr++ and go to SCAN.
  - DONE: drain_done=1 and busy=0 for one cycle, then IDLE.
  - drain_req is ignored outside IDLE.
  - clear_req during a drain: clears everything, drops dr_valid, and goes to DONE (drain_done still pulses).
- Worst-case drain of an empty memory takes 2^A+2 cycles.
- Reset mid-drain: FSM goes to IDLE immediately, busy=0, and no drain_done pulse is emitted.
- count saturates by construction: maximum 2^A, minimum 0.

Decomposition:
- Shared package: drain FSM state enum, RD_LAT legality check constant, and the flattened-bus slice helpers.
- One sub-module, rr_arbiter (parameter NCH): req vector in, one-hot grant out, pointer update on grant.

Test Plan:
1. Reset, then read address 5 -> rd_vld at t+RD_LAT with rd_data=0, rd_hit=0, count=0.
2. Ch0 and ch1 both write, to addr 3 (0xAAAAAA) and addr 4 (0x555555), in the same cycle -> ch0 granted first and ch1 the next cycle. Reads then return the matching data with hit=1, and count=2.
3. Rewrite addr 3 with 0x123456 -> count stays 2. A same-cycle read of addr 3 returns 0xAAAAAA (read-first).
4. Write addrs 0, 7 and 511, then pulse drain_req while holding dr_ready=0 for 3 cycles -> dr_valid holds addr 0 stable. Releasing dr_ready gives addr 0, then 7, then 511, followed by a drain_done pulse. count=0 and busy=0 afterwards.
5. clear_req asserted in the same cycle as a write to addr 9 -> wr_ready=0, and count=0 next cycle. A read of addr 9 gives hit=0.
6. Assert reset during OUT of a drain -> busy=0, dr_valid=0, count=0 next cycle, and no drain_done pulse.
